// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - per-note ADSR gain generator; `define ADSR_EXP_RELEASE_EN selects exponential release
module adsr_envelope #(
    parameter int LEVEL_BITS = 24,
    parameter int RATE_BITS  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 tick_in,
    input  logic                 gate_on_in,
    input  logic                 gate_off_in,
    input  logic [6:0]           velocity_in,
    input  logic [RATE_BITS-1:0] attack_rate_in,
    input  logic [RATE_BITS-1:0] decay_rate_in,
    input  logic [7:0]           sustain_level_in,
    input  logic [RATE_BITS-1:0] release_rate_in,
    output logic [7:0]           env_out,
    output logic [2:0]           stage_out,
    output logic                 active_out
);

    localparam int SHIFT = LEVEL_BITS - 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_t;

    stage_t                stage, stage_nxt;
    logic [LEVEL_BITS-1:0] level, level_nxt;
    logic [LEVEL_BITS-1:0] peak, peak_nxt;
    logic                  active;

    logic [7:0]            sus_gain;
    logic [LEVEL_BITS-1:0] sus_full;
    logic [LEVEL_BITS-1:0] sustain_tgt;
    logic [LEVEL_BITS:0]   level_ext;
    logic [LEVEL_BITS:0]   attack_sum;
    logic [LEVEL_BITS:0]   decay_diff;
    logic [LEVEL_BITS:0]   rel_diff;
    logic                  rel_instant;

    assign sus_gain    = (sustain_level_in > 8'd128) ? 8'd128 : sustain_level_in;
    assign sus_full    = {sus_gain, {SHIFT{1'b0}}};
    assign sustain_tgt = (sus_full > peak) ? peak : sus_full;

    // One extra bit so sums and differences can be saturated instead of wrapping
    assign level_ext  = {1'b0, level};
    assign attack_sum = level_ext + (LEVEL_BITS+1)'(attack_rate_in);
    assign decay_diff = level_ext - (LEVEL_BITS+1)'(decay_rate_in);

`ifdef ADSR_EXP_RELEASE_EN
    assign rel_diff    = level_ext - ({1'b0, level >> release_rate_in[3:0]} + 1'b1);
    assign rel_instant = (release_rate_in[3:0] == 4'd0);
`else
    assign rel_diff    = level_ext - (LEVEL_BITS+1)'(release_rate_in);
    assign rel_instant = (release_rate_in == '0);
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stage  <= ST_IDLE;
            level  <= '0;
            peak   <= '0;
            active <= 1'b0;
        end else begin
            stage  <= stage_nxt;
            level  <= level_nxt;
            peak   <= peak_nxt;
            active <= (stage_nxt != ST_IDLE);
        end
    end

    always_comb begin
        stage_nxt = stage;
        level_nxt = level;
        peak_nxt  = peak;
        // Gate events consume any coincident tick; level is kept so retriggers do not click
        if (gate_on_in) begin
            peak_nxt  = {8'(velocity_in) + 8'd1, {SHIFT{1'b0}}};
            stage_nxt = ST_ATTACK;
        end else if (gate_off_in && (stage == ST_ATTACK || stage == ST_DECAY ||
                                     stage == ST_SUSTAIN)) begin
            stage_nxt = ST_RELEASE;
        end else if (tick_in) begin
            case (stage)
                ST_ATTACK: begin
                    if (attack_rate_in == '0 || level >= peak || attack_sum >= {1'b0, peak}) begin
                        level_nxt = peak;
                        stage_nxt = ST_DECAY;
                    end else begin
                        level_nxt = attack_sum[LEVEL_BITS-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_rate_in == '0 || decay_diff[LEVEL_BITS] ||
                        decay_diff[LEVEL_BITS-1:0] <= sustain_tgt) begin
                        level_nxt = sustain_tgt;
                        stage_nxt = ST_SUSTAIN;
                    end else begin
                        level_nxt = decay_diff[LEVEL_BITS-1:0];
                    end
                end
                ST_SUSTAIN: level_nxt = sustain_tgt;
                ST_RELEASE: begin
                    if (rel_instant || rel_diff[LEVEL_BITS] || rel_diff[LEVEL_BITS-1:0] == '0) begin
                        level_nxt = '0;
                        stage_nxt = ST_IDLE;
                    end else begin
                        level_nxt = rel_diff[LEVEL_BITS-1:0];
                    end
                end
                default: level_nxt = '0;
            endcase
        end
    end

    assign env_out    = level[LEVEL_BITS-1 -: 8];
    assign stage_out  = stage;
    assign active_out = active;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed and randomized checks of adsr_envelope against a behavioural model
module tb_adsr_envelope;

    localparam int LB = 24;
    localparam int RB = 20;
    localparam int S  = LB - 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          tick_in = 1'b0;
    logic          gate_on_in = 1'b0;
    logic          gate_off_in = 1'b0;
    logic [6:0]    velocity_in = '0;
    logic [RB-1:0] attack_rate_in = '0;
    logic [RB-1:0] decay_rate_in = '0;
    logic [7:0]    sustain_level_in = '0;
    logic [RB-1:0] release_rate_in = '0;
    logic [7:0]    env_out;
    logic [2:0]    stage_out;
    logic          active_out;

    int n_checks = 0;
    int n_errors = 0;

    longint m_level = 0;
    longint m_peak  = 0;
    int     m_stage = 0;

    adsr_envelope #(.LEVEL_BITS(LB), .RATE_BITS(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in),
        .gate_on_in(gate_on_in), .gate_off_in(gate_off_in), .velocity_in(velocity_in),
        .attack_rate_in(attack_rate_in), .decay_rate_in(decay_rate_in),
        .sustain_level_in(sustain_level_in), .release_rate_in(release_rate_in),
        .env_out(env_out), .stage_out(stage_out), .active_out(active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Envelope rules stated as plain integer arithmetic on the gain scale
    task automatic model_step(input bit on, input bit off, input bit tk);
        longint sus, nl;
        int sh;
        sus = ((sustain_level_in > 128) ? 128 : longint'(sustain_level_in)) << S;
        if (sus > m_peak) sus = m_peak;
        if (on) begin
            m_peak  = (longint'(velocity_in) + 1) << S;
            m_stage = 1;
        end else if (off && m_stage >= 1 && m_stage <= 3) begin
            m_stage = 4;
        end else if (tk) begin
            case (m_stage)
                1: begin
                    nl = m_level + longint'(attack_rate_in);
                    if (attack_rate_in == 0 || nl >= m_peak) begin
                        m_level = m_peak; m_stage = 2;
                    end else m_level = nl;
                end
                2: begin
                    nl = m_level - longint'(decay_rate_in);
                    if (decay_rate_in == 0 || nl <= sus) begin
                        m_level = sus; m_stage = 3;
                    end else m_level = nl;
                end
                3: m_level = sus;
                4: begin
`ifdef ADSR_EXP_RELEASE_EN
                    sh = int'(release_rate_in % 16);
                    nl = m_level - ((m_level >> sh) + 1);
                    if (sh == 0) nl = 0;
`else
                    sh = 0;
                    nl = m_level - longint'(release_rate_in);
                    if (release_rate_in == 0) nl = 0;
`endif
                    if (nl <= 0) begin
                        m_level = 0; m_stage = 0;
                    end else m_level = nl;
                end
                default: m_level = 0;
            endcase
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_peak = 0; m_stage = 0;
    endtask

    task automatic step(input bit on, input bit off, input bit tk);
        gate_on_in = on; gate_off_in = off; tick_in = tk;
        model_step(on, off, tk);
        @(posedge clk_in); #1;
        gate_on_in = 1'b0; gate_off_in = 1'b0; tick_in = 1'b0;
        check("env", env_out, m_level >> S);
        check("stage", stage_out, m_stage);
        check("active", active_out, m_stage != 0);
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            step(0, 0, 0);
            step(0, 0, 0);
            step(0, 0, 1);
        end
    endtask

    function automatic logic [RB-1:0] rnd_rate();
        if ($urandom_range(0, 7) == 0) return '0;
        return RB'($urandom_range(1, (1 << RB) - 1) >> $urandom_range(0, 8));
    endfunction

    initial begin
        longint pre;
        bit done;
        int cyc;
        bit on, off, tk;

        repeat (3) @(posedge clk_in);
        #1;
        check("reset_env", env_out, 0);
        check("reset_stage", stage_out, 0);
        check("reset_active", active_out, 0);
        rst_in = 1'b1;
        model_reset();

        // Attack to unity, decay to half
        attack_rate_in = 20'h08000; decay_rate_in = 20'h10000;
        sustain_level_in = 8'd64; release_rate_in = 20'h40000; velocity_in = 7'd127;
        step(1, 0, 0);
        check("gate_on_stage", stage_out, 1);
        run_ticks(255);
        check("attack_255", env_out, 127);
        run_ticks(1);
        check("attack_256_env", env_out, 128);
        check("attack_256_stage", stage_out, 2);
        run_ticks(63);
        check("decay_63", env_out, 65);
        run_ticks(1);
        check("decay_64_env", env_out, 64);
        check("decay_64_stage", stage_out, 3);
        run_ticks(3);

`ifndef ADSR_EXP_RELEASE_EN
        step(0, 1, 0);
        check("gate_off_stage", stage_out, 4);
        run_ticks(15);
        check("release_15", env_out, 4);
        run_ticks(1);
        check("release_env", env_out, 0);
        check("release_idle", stage_out, 0);
        check("release_inactive", active_out, 0);

        // Retrigger from level 40 during release at a lower velocity
        attack_rate_in = '0; decay_rate_in = '0; sustain_level_in = 8'd80;
        release_rate_in = 20'h80000;
        step(1, 0, 0);
        run_ticks(2);
        step(0, 1, 0);
        run_ticks(5);
        check("retrig_pre_env", env_out, 40);
        check("retrig_pre_stage", stage_out, 4);
        velocity_in = 7'd63; attack_rate_in = 20'h30000;
        step(1, 0, 0);
        check("retrig_no_drop", env_out, 40);
        check("retrig_stage", stage_out, 1);
        run_ticks(1);
        check("retrig_up", env_out, 43);
        run_ticks(7);
        check("retrig_peak_env", env_out, 64);
        check("retrig_peak_stage", stage_out, 2);
        run_ticks(1);
        check("sus_clamp_env", env_out, 64);
        check("sus_clamp_stage", stage_out, 3);
`else
        attack_rate_in = '0;
        step(1, 0, 0);
        run_ticks(1);
        check("exp_peak", env_out, 128);
        release_rate_in = 20'h00002;
        step(0, 1, 0);
        run_ticks(1);
        check("exp_first_tick", env_out, 95);
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            run_ticks(1);
            if (stage_out == 3'd0) done = 1'b1;
        end
        check("exp_reaches_idle", done, 1);
        check("exp_env_zero", env_out, 0);
`endif

        // Simultaneous gate_on, gate_off and tick
        velocity_in = 7'd127;
        pre = m_level >> S;
        step(1, 1, 1);
        check("simul_stage", stage_out, 1);
        check("simul_env_held", env_out, pre);

        // Asynchronous reset mid-decay
        attack_rate_in = '0; decay_rate_in = 20'h10000; sustain_level_in = 8'd32;
        run_ticks(1);
        run_ticks(2);
        check("pre_reset_stage", stage_out, 2);
        #2 rst_in = 1'b0;
        #1;
        check("async_reset_env", env_out, 0);
        check("async_reset_stage", stage_out, 0);
        check("async_reset_active", active_out, 0);
        model_reset();
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Randomized traffic
        for (cyc = 0; cyc < 6000; cyc++) begin
            if (cyc % 250 == 0) begin
                attack_rate_in   = rnd_rate();
                decay_rate_in    = rnd_rate();
                release_rate_in  = rnd_rate();
                sustain_level_in = 8'($urandom_range(0, 255));
            end
            if (cyc % 40 == 7) sustain_level_in = 8'($urandom_range(0, 160));
            tk  = (cyc % 3 == 2);
            on  = ($urandom_range(0, 79) == 0);
            off = ($urandom_range(0, 49) == 0);
            if (off && tk && !(m_stage >= 1 && m_stage <= 3)) off = 1'b0;
            if (on) velocity_in = 7'($urandom_range(0, 127));
            step(on, off, tk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
